// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter: FSM states,
// round-robin pick function and id-width helper.
package sram_arb_pkg;

  typedef enum logic {
    INIT,
    RUN
  } arb_state_e;

  localparam int unsigned RR_MAX_N = 32;
  localparam int unsigned RR_IDX_W = $clog2(RR_MAX_N);

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First asserted request searching from ptr+1 with wrap at n; one-hot result.
  function automatic logic [RR_MAX_N-1:0] rr_pick(input logic [RR_MAX_N-1:0] req,
                                                  input int unsigned ptr,
                                                  input int unsigned n);
    logic [RR_MAX_N-1:0] gnt;
    logic [RR_IDX_W-1:0] idx;
    logic                found;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX_N; k++) begin
      if (k <= n) begin
        idx = RR_IDX_W'((ptr + k) % n);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/sram_if.sv
// Dual-address SRAM interface: active-low read/write strobes, separate addresses.
interface sram_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 13
);
  logic              rd_l;
  logic              wr_l;
  logic [ADDR_W-1:0] rd_address;
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport initiator (output rd_l, wr_l, rd_address, wr_address, wdata, input rdata);
  modport target    (input rd_l, wr_l, rd_address, wr_address, wdata, output rdata);
endinterface

// File: rtl/sram_port_arbiter_rr.sv
// Round-robin arbiter over N requesters; pointer moves to the winner only on a grant.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned ID_W = id_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    gnt    = en ? N'(rr_pick(RR_MAX_N'(req), 32'(ptr_q), N)) : '0;
    gnt_id = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) gnt_id = ID_W'(i);
    end
    ptr_d = (|gnt) ? gnt_id : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= ID_W'(N - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one dual-address SRAM between read and write requesters with
// independent round-robin channels, tagged read returns and optional zero-fill.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned NUM_RD  = 4,
  parameter int unsigned NUM_WR  = 2,
  parameter int unsigned RD_LAT  = 1,
  parameter bit          INIT_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  sram_if.initiator                sram,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_gnt,
  output logic [NUM_RD-1:0]        rd_vld,
  output logic [DATA_W-1:0]        rd_data,
  input  logic [NUM_WR-1:0]        wr_req,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [NUM_WR-1:0]        wr_gnt,
  output logic                     init_done
);

  localparam int unsigned RID_W = id_w(NUM_RD);
  localparam int unsigned WID_W = id_w(NUM_WR);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;
  logic              rd_l_q, rd_l_d, wr_l_q, wr_l_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [RD_LAT:0]   pv_q, pv_d;
  logic [RID_W-1:0]  pid_q [RD_LAT+1];
  logic [RID_W-1:0]  pid_d [RD_LAT+1];
  logic [RID_W-1:0]  rd_id;
  logic [WID_W-1:0]  wr_id;

  rr_arbiter #(.N(NUM_RD)) u_rd_arb (
    .clk(clk), .rst(rst), .en(init_done_q), .req(rd_req), .gnt(rd_gnt), .gnt_id(rd_id)
  );

  rr_arbiter #(.N(NUM_WR)) u_wr_arb (
    .clk(clk), .rst(rst), .en(init_done_q), .req(wr_req), .gnt(wr_gnt), .gnt_id(wr_id)
  );

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    // init_done lags the last init write by one cycle, gating grants until then
    init_done_d = init_done_q | (state_q == RUN);
    rd_l_d      = 1'b1;
    wr_l_d      = 1'b1;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wdata_d     = wdata_q;
    case (state_q)
      INIT: begin
        wr_l_d     = 1'b0;
        wr_addr_d  = init_cnt_q;
        wdata_d    = '0;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (&init_cnt_q) state_d = RUN;
      end
      RUN: begin
        if (|rd_gnt) begin
          rd_l_d    = 1'b0;
          rd_addr_d = rd_addr[32'(rd_id)*ADDR_W +: ADDR_W];
        end
        if (|wr_gnt) begin
          wr_l_d    = 1'b0;
          wr_addr_d = wr_addr[32'(wr_id)*ADDR_W +: ADDR_W];
          wdata_d   = wr_data[32'(wr_id)*DATA_W +: DATA_W];
        end
      end
      default: state_d = RUN;
    endcase

    pv_d[0]  = |rd_gnt;
    pid_d[0] = rd_id;
    for (int unsigned i = 1; i <= RD_LAT; i++) begin
      pv_d[i]  = pv_q[i-1];
      pid_d[i] = pid_q[i-1];
    end

    rd_vld = '0;
    if (pv_q[RD_LAT]) rd_vld[pid_q[RD_LAT]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT_EN ? INIT : RUN;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rd_l_q      <= 1'b1;
      wr_l_q      <= 1'b1;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wdata_q     <= '0;
      pv_q        <= '0;
      for (int unsigned i = 0; i <= RD_LAT; i++) pid_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rd_l_q      <= rd_l_d;
      wr_l_q      <= wr_l_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wdata_q     <= wdata_d;
      pv_q        <= pv_d;
      for (int unsigned i = 0; i <= RD_LAT; i++) pid_q[i] <= pid_d[i];
    end
  end

  assign sram.rd_l       = rd_l_q;
  assign sram.wr_l       = wr_l_q;
  assign sram.rd_address = rd_addr_q;
  assign sram.wr_address = wr_addr_q;
  assign sram.wdata      = wdata_q;
  assign rd_data         = sram.rdata;
  assign init_done       = init_done_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized held requests,
// checked against a transaction-level model of grants, SRAM contents and returns.
module tb_sram_port_arbiter;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned NUM_RD  = 4;
  localparam int unsigned NUM_WR  = 2;
  localparam int unsigned RD_LAT  = 1;
  localparam bit          INIT_EN = 1'b1;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_RD-1:0]        rd_req, rd_gnt, rd_vld;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic [NUM_WR-1:0]        wr_req, wr_gnt;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     init_done;

  sram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) sram ();

  sram_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
    .NUM_WR(NUM_WR), .RD_LAT(RD_LAT), .INIT_EN(INIT_EN)
  ) dut (
    .clk(clk), .rst(rst), .sram(sram),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .init_done(init_done)
  );

  // SRAM behavioural model: read-before-write, RD_LAT cycles of read latency
  logic              scramble;
  logic [DATA_W-1:0] mem   [DEPTH];
  logic [DATA_W-1:0] rpipe [RD_LAT];
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= DATA_W'($urandom);
    end else if (!sram.wr_l) begin
      mem[sram.wr_address] <= sram.wdata;
    end
    if (!sram.rd_l) rpipe[0] <= mem[sram.rd_address];
    for (int i = 1; i < int'(RD_LAT); i++) rpipe[i] <= rpipe[i-1];
  end
  assign sram.rdata = rpipe[RD_LAT-1];

  // Reference model state
  typedef struct {
    int unsigned       due;
    int unsigned       id;
    logic [DATA_W-1:0] data;
  } ret_t;

  ret_t              retq[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int unsigned       rd_ptr, wr_ptr, cyc;
  logic              e_rd_l, e_wr_l;
  logic [ADDR_W-1:0] e_rd_a, e_wr_a;
  logic [DATA_W-1:0] e_wd;
  int unsigned       e_rd_id;
  int                checks = 0;
  int                errors = 0;
  int                rg, wg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [31:0] req, input int unsigned ptr, input int unsigned n);
    for (int unsigned k = 1; k <= n; k++) begin
      if (req[(ptr + k) % n]) return int'((ptr + k) % n);
    end
    return -1;
  endfunction

  // One arbitration cycle: entered and left 1 time unit after a rising edge
  task automatic run_cycle(input logic [NUM_RD-1:0] rq, input logic [NUM_RD*ADDR_W-1:0] ra,
                           input logic [NUM_WR-1:0] wq, input logic [NUM_WR*ADDR_W-1:0] wa,
                           input logic [NUM_WR*DATA_W-1:0] wd, output int rgo, output int wgo);
    logic [63:0] exp_vld;
    ret_t        r;
    rd_req = rq; rd_addr = ra; wr_req = wq; wr_addr = wa; wr_data = wd;
    #1;
    chk("rd_l", sram.rd_l, e_rd_l);
    chk("rd_address", sram.rd_address, e_rd_a);
    chk("wr_l", sram.wr_l, e_wr_l);
    chk("wr_address", sram.wr_address, e_wr_a);
    chk("wdata", sram.wdata, e_wd);
    chk("init_done_run", init_done, 1);
    if (!e_rd_l) retq.push_back('{cyc + RD_LAT, e_rd_id, ref_mem[e_rd_a]});
    exp_vld = '0;
    if (retq.size() > 0 && retq[0].due == cyc) begin
      r = retq.pop_front();
      exp_vld = 64'(1) << r.id;
      chk("rd_data", rd_data, r.data);
    end
    chk("rd_vld", rd_vld, exp_vld);
    if (!e_wr_l) ref_mem[e_wr_a] = e_wd;
    rgo = pick(32'(rq), rd_ptr, NUM_RD);
    wgo = pick(32'(wq), wr_ptr, NUM_WR);
    chk("rd_gnt", rd_gnt, (rgo >= 0) ? (64'(1) << rgo) : 64'(0));
    chk("wr_gnt", wr_gnt, (wgo >= 0) ? (64'(1) << wgo) : 64'(0));
    e_rd_l = 1'b1;
    e_wr_l = 1'b1;
    if (rgo >= 0) begin
      e_rd_l  = 1'b0;
      e_rd_a  = ra[rgo*ADDR_W +: ADDR_W];
      e_rd_id = rgo;
      rd_ptr  = rgo;
    end
    if (wgo >= 0) begin
      e_wr_l = 1'b0;
      e_wr_a = wa[wgo*ADDR_W +: ADDR_W];
      e_wd   = wd[wgo*DATA_W +: DATA_W];
      wr_ptr = wgo;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    int a, b;
    for (int i = 0; i < n; i++) run_cycle('0, '0, '0, '0, '0, a, b);
  endtask

  // Reset for nrst edges, then follow the zero-fill sweep and reset the model
  task automatic init_seq(input int nrst);
    rst = 1'b1;
    rd_req = '0; wr_req = '0;
    repeat (nrst) @(posedge clk);
    #1;
    chk("rst_rd_l", sram.rd_l, 1);
    chk("rst_wr_l", sram.wr_l, 1);
    chk("rst_rd_address", sram.rd_address, 0);
    chk("rst_wr_address", sram.wr_address, 0);
    chk("rst_wdata", sram.wdata, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_init_done", init_done, 0);
    rst = 1'b0;
    rd_req = '1; rd_addr = '1; wr_req = '1; wr_addr = '1; wr_data = '1;
    for (int k = 0; k < int'(DEPTH); k++) begin
      @(posedge clk); #1;
      chk("init_wr_l", sram.wr_l, 0);
      chk("init_wr_address", sram.wr_address, 64'(k));
      chk("init_wdata", sram.wdata, 0);
      chk("init_rd_l", sram.rd_l, 1);
      chk("init_done_low", init_done, 0);
      chk("init_rd_gnt", rd_gnt, 0);
      chk("init_wr_gnt", wr_gnt, 0);
      chk("init_rd_vld", rd_vld, 0);
    end
    rd_req = '0; wr_req = '0;
    @(posedge clk); #1;
    chk("init_done_rise", init_done, 1);
    chk("init_end_wr_l", sram.wr_l, 1);
    rd_ptr = NUM_RD - 1;
    wr_ptr = NUM_WR - 1;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    retq.delete();
    e_rd_l = 1'b1; e_wr_l = 1'b1;
    e_rd_a = '0;   e_wr_a = ADDR_W'(DEPTH - 1);
    e_wd   = '0;   e_rd_id = 0;
    cyc    = 0;
  endtask

  logic [NUM_RD-1:0]        pend_r;
  logic [NUM_RD*ADDR_W-1:0] pend_ra;
  logic [NUM_WR-1:0]        pend_w;
  logic [NUM_WR*ADDR_W-1:0] pend_wa;
  logic [NUM_WR*DATA_W-1:0] pend_wd;

  initial begin
    rst = 1'b1; scramble = 1'b1;
    rd_req = '0; rd_addr = '0; wr_req = '0; wr_addr = '0; wr_data = '0;
    @(posedge clk); #1;
    scramble = 1'b0;
    init_seq(2);

    // Fairness: all readers held for 8 cycles, pointer starts at last index
    for (int i = 0; i < 8; i++) begin
      run_cycle('1, {4'd11, 4'd10, 4'd9, 4'd8}, '0, '0, '0, rg, wg);
      chk("rr_order", 64'(rg), 64'(i % 4));
    end
    idle(3);

    // Concurrent read and write, then read back the written word
    run_cycle(4'b0001, {12'h0, 4'h7}, 2'b10, {4'h3, 4'h0}, {16'h00A5, 16'h0}, rg, wg);
    chk("conc_rd_gnt_id", 64'(rg), 0);
    chk("conc_wr_gnt_id", 64'(wg), 1);
    idle(1);
    run_cycle(4'b0001, {12'h0, 4'h3}, '0, '0, '0, rg, wg);
    idle(3);

    // Single read of word 5 by requester 2
    run_cycle('0, '0, 2'b01, {4'h0, 4'h5}, {16'h0, 16'hBEEF}, rg, wg);
    idle(1);
    run_cycle(4'b0100, {4'h0, 4'h5, 8'h0}, '0, '0, '0, rg, wg);
    chk("single_rd_gnt_id", 64'(rg), 2);
    idle(3);

    // Pointer hold across idle cycles
    run_cycle(4'b0010, {8'h0, 4'h1, 4'h0}, '0, '0, '0, rg, wg);
    chk("hold_first", 64'(rg), 1);
    idle(3);
    run_cycle(4'b0101, {4'h0, 4'h2, 4'h0, 4'h4}, '0, '0, '0, rg, wg);
    chk("hold_second", 64'(rg), 2);
    run_cycle(4'b0001, {12'h0, 4'h4}, '0, '0, '0, rg, wg);
    chk("hold_third", 64'(rg), 0);
    idle(3);

    // Random held requests on both channels
    pend_r = '0; pend_ra = '0; pend_w = '0; pend_wa = '0; pend_wd = '0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < int'(NUM_RD); i++) begin
        if (!pend_r[i] && $urandom_range(0, 1) == 1) begin
          pend_r[i] = 1'b1;
          pend_ra[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, DEPTH - 1));
        end
      end
      for (int i = 0; i < int'(NUM_WR); i++) begin
        if (!pend_w[i] && $urandom_range(0, 2) == 0) begin
          pend_w[i] = 1'b1;
          pend_wa[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, DEPTH - 1));
          pend_wd[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
      end
      run_cycle(pend_r, pend_ra, pend_w, pend_wa, pend_wd, rg, wg);
      if (rg >= 0) pend_r[rg] = 1'b0;
      if (wg >= 0) pend_w[wg] = 1'b0;
    end
    idle(3);

    // Reset in the cycle before a read return is due
    run_cycle(4'b0001, {12'h0, 4'h1}, 2'b01, {4'h0, 4'h2}, {16'h0, 16'h1234}, rg, wg);
    init_seq(1);
    for (int n = 0; n < 20; n++) begin
      run_cycle(4'($urandom), 16'($urandom), 2'($urandom), 8'($urandom), 32'($urandom), rg, wg);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one dual-address SRAM between NUM_RD read requesters and NUM_WR write requesters.
- Drives the initiator side of the SRAM interface, with independent round-robin arbiters on the read and write channels.
- Tags each read return with its originating requester.
- Optionally zero-fills the SRAM after reset before any requester is granted.

Parameters:
- DATA_W, 64, SRAM data width
- ADDR_W, 13, SRAM address width; depth is 2**ADDR_W
- NUM_RD, 4, read requesters (>=1)
- NUM_WR, 2, write requesters (>=1)
- RD_LAT, 1, SRAM read latency: cycles from rd_l-low cycle to rdata valid (>=1)
- INIT_EN, 1, 1 = zero-fill the SRAM after reset; 0 = skip

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous active-high reset
- sram  sram_if.initiator  -  SRAM interface, DATA_W/ADDR_W matching the parameters
- rd_req  in  NUM_RD  per-requester read request; held until granted
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; requester i uses slice i
- rd_gnt  out  NUM_RD  one-hot read grant, combinational, same cycle as the request
- rd_vld  out  NUM_RD  one-hot read-return strobe
- rd_data  out  DATA_W  read data; valid where rd_vld is nonzero
- wr_req  in  NUM_WR  per-requester write request; held until granted
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses
- wr_data  in  NUM_WR*DATA_W  packed write data
- wr_gnt  out  NUM_WR  one-hot write grant, combinational
- init_done  out  1  high once initialisation is complete; remains high until the next rst

Behaviour:
- Reset state (rst high at an edge):
  - sram.rd_l=1, sram.wr_l=1; addresses and wdata = 0.
  - rd_vld=0; return pipeline cleared; init_done=0.
  - Both RR pointers = last index, so requester 0 has first priority.
  - FSM enters INIT if INIT_EN=1, else RUN.
- INIT state:
  - Grants are forced to 0.
  - Each cycle: wr_l=0, wr_address=counter, wdata=0; counter increments.
  - After writing address 2**ADDR_W-1: wr_l returns to 1, init_done=1, FSM goes to RUN. The counter wraps to 0 and is unused thereafter.
  - Reads are not issued during INIT.
- RUN state, read arbitration:
  - Grant goes to the first asserted rd_req searching from pointer+1 with modulo-NUM_RD wrap.
  - The pointer updates to the granted index only on a grant; it holds when there are no requests.
- RUN state, write arbitration: identical, independent pointer over NUM_WR.
- SRAM drive (registered): a grant in cycle t produces, in cycle t+1:
  - for a read: rd_l=0, rd_address = granted address;
  - for a write: wr_l=0, wr_address and wdata = granted values.
  - With no grant, the strobe is 1 and address/data hold their previous values.
- Throughput: one read and one write can issue per cycle. With one requester holding req, it is granted every cycle.
- Read return:
  - The requester id travels a (1+RD_LAT)-deep valid/id shift register.
  - rd_vld[id] is asserted in cycle t+1+RD_LAT; rd_data = sram.rdata, passed through combinationally.
  - Back-to-back reads return back-to-back, in grant order.
- Same-address read and write in the same cycle: both are issued. The data returned is defined by the SRAM; the arbiter does no forwarding.
- Reset mid-operation:
  - Outstanding returns are discarded; no rd_vld after reset.
  - If INIT_EN=1, INIT restarts from address 0.
- Requests asserted before init_done are ignored (no grant) and are simply held by the requester.

Decomposition:
- Shared package sram_arb_pkg holds:
  - the FSM state enum {INIT, RUN};
  - a function rr_pick(req, ptr), returning a one-hot grant;
  - an id-width helper, $clog2 with a minimum of 1.
- One natural sub-module, rr_arbiter, parameterised on N (req, ptr update, one-hot gnt, encoded id). Instantiated twice: read channel and write channel.

Test Plan:
- Init sweep (ADDR_W=4, INIT_EN=1):
  - rst for 2 cycles, then release.
  - Required: wr_l=0 for exactly 16 cycles at addresses 0..15 with wdata=0.
  - init_done rises the cycle after address 15; no grants before that.
- Single read (RD_LAT=1):
  - rd_req[2]=1 with rd_addr[2]=0x05 in cycle t.
  - Required: rd_gnt=0100 in t; rd_l=0 with rd_address=0x05 in t+1; rd_vld=0100 in t+2 with rd_data = the SRAM model's word 5.
- Round-robin fairness (NUM_RD=4): all rd_req held for 8 cycles.
  - Required grant sequence: 0,1,2,3,0,1,2,3; rd_vld follows the same order, 2 cycles later.
- Concurrent read and write:
  - In the same cycle: wr_req[1] addr 0x3 data 0xA5, and rd_req[0] addr 0x7.
  - Required: both granted; wr_l=0 and rd_l=0 in the same next cycle; wdata=0xA5.
  - A later read of 0x3 returns 0xA5.
- Pointer hold: grant requester 1, idle 3 cycles, then assert requesters 0 and 2.
  - Required: requester 2 is granted first, then 0.
- Mid-flight reset: issue reads, then pulse rst in the cycle before rd_vld is due.
  - Required: no rd_vld pulse; rd_l=1 and wr_l=1 after reset; INIT restarts at address 0.
